// File: rtl/dlfloat_result_serializer.sv
// rtl/dlfloat_result_serializer.sv - DLFloat result FIFO with low-byte-first byte serializer
// Buffers 16-bit results and emits each as two bytes with NaN/zero tags and a saturating word count.
module dlfloat_result_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_hi,
  output logic        flag_nan,
  output logic        flag_zero,
  output logic [7:0]  word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  state;
  logic [15:0] hold;
  logic        nan_q;
  logic        zero_q;
  logic [7:0]  wc_q;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign in_ready = !full;
  assign push     = in_valid && !full && !clear;
  assign pop      = !empty && !clear &&
                    ((state == S_IDLE) || ((state == S_HI) && out_ready));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= S_IDLE;
      hold   <= '0;
      nan_q  <= 1'b0;
      zero_q <= 1'b0;
      wc_q   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= S_IDLE;
      hold   <= '0;
      nan_q  <= 1'b0;
      zero_q <= 1'b0;
      wc_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold   <= head;
        nan_q  <= (head == 16'hFFFF);
        zero_q <= (head == 16'h0000);
        state  <= S_LO;
      end else begin
        case (state)
          S_LO: begin
            if (out_ready) begin
              state <= S_HI;
            end
          end
          S_HI: begin
            if (out_ready) begin
              state  <= S_IDLE;
              nan_q  <= 1'b0;
              zero_q <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if ((state == S_HI) && out_ready && (wc_q != 8'hFF)) begin
        wc_q <= wc_q + 8'd1;
      end
    end
  end

  assign out_valid  = (state == S_LO) || (state == S_HI);
  assign out_hi     = (state == S_HI);
  assign flag_nan   = nan_q;
  assign flag_zero  = zero_q;
  assign word_count = wc_q;

  always_comb begin
    out_byte = 8'h00;
    if (state == S_LO) begin
      out_byte = hold[7:0];
    end else if (state == S_HI) begin
      out_byte = hold[15:8];
    end
  end

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// tb/tb_dlfloat_result_serializer.sv - self-checking bench for dlfloat_result_serializer
// Queue-based transaction model checked every cycle, plus directed literal checks.
module tb_dlfloat_result_serializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_hi;
  logic        flag_nan;
  logic        flag_zero;
  logic [7:0]  word_count;

  int checks = 0;
  int errs = 0;

  dlfloat_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .flag_nan(flag_nan), .flag_zero(flag_zero),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accepted words wait in q; cur_* is the word currently on the byte port.
  logic [15:0] q[$];
  logic [15:0] cur_w = 16'h0;
  bit          cur_v = 0;
  bit          cur_hi = 0;
  int          m_wc = 0;
  bit          model_on = 1;

  always @(posedge clk) begin
    int pre_size;
    if (!rst_n || clear) begin
      q.delete();
      cur_v = 0; cur_hi = 0; m_wc = 0;
    end else begin
      pre_size = q.size();
      if (!cur_v) begin
        if (pre_size > 0) begin cur_w = q.pop_front(); cur_v = 1; cur_hi = 0; end
      end else if (!cur_hi) begin
        if (out_ready) cur_hi = 1;
      end else if (out_ready) begin
        if (m_wc < 255) m_wc++;
        if (pre_size > 0) begin cur_w = q.pop_front(); cur_hi = 0; end
        else begin cur_v = 0; cur_hi = 0; end
      end
      if (in_valid && pre_size < DEPTH) q.push_back(in_data);
    end
    #1;
    if (model_on) begin
      chk("m_out_valid", out_valid, cur_v);
      chk("m_out_hi", out_hi, cur_v && cur_hi);
      chk("m_out_byte", out_byte, !cur_v ? 0 : (cur_hi ? cur_w[15:8] : cur_w[7:0]));
      chk("m_flag_nan", flag_nan, cur_v && cur_w == 16'hFFFF);
      chk("m_flag_zero", flag_zero, cur_v && cur_w == 16'h0000);
      chk("m_word_count", word_count, m_wc);
      chk("m_in_ready", in_ready, q.size() < DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] got[$];
    int n;
    int wc0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_word_count", word_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word 3E00
    out_ready = 1; in_valid = 1; in_data = 16'h3E00;
    tick();
    in_valid = 0;
    tick();
    chk("w3e_lo_byte", out_byte, 8'h00);
    chk("w3e_lo_hi", out_hi, 0);
    chk("w3e_lo_valid", out_valid, 1);
    chk("w3e_flags", {flag_nan, flag_zero}, 0);
    tick();
    chk("w3e_hi_byte", out_byte, 8'h3E);
    chk("w3e_hi_hi", out_hi, 1);
    tick();
    chk("w3e_count", word_count, 1);
    chk("w3e_idle", out_valid, 0);

    // NaN then zero back-to-back
    in_valid = 1; in_data = 16'hFFFF;
    tick();
    in_data = 16'h0000;
    tick();
    in_valid = 0;
    chk("nan_lo", out_byte, 8'hFF);
    chk("nan_flag_lo", flag_nan, 1);
    tick();
    chk("nan_hi", out_byte, 8'hFF);
    chk("nan_flag_hi", flag_nan, 1);
    tick();
    chk("zero_lo", out_byte, 8'h00);
    chk("zero_flag_lo", flag_zero, 1);
    chk("zero_nan_lo", flag_nan, 0);
    tick();
    chk("zero_hi", out_byte, 8'h00);
    chk("zero_flag_hi", flag_zero, 1);
    tick();
    chk("nz_count", word_count, 3);

    // Fill with out_ready low: DEPTH+1 accepted, one more rejected
    out_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1; in_data = 16'hA100 + 16'(i);
      tick();
      if (i == DEPTH) chk("fill_in_ready_low", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (out_valid && n < 40) begin
      got.push_back(out_byte);
      tick();
      n++;
    end
    chk("fill_byte_count", got.size(), 2 * (DEPTH + 1));
    for (int i = 0; i < DEPTH + 1 && 2 * i + 1 < got.size(); i++) begin
      chk("fill_lo", got[2 * i], 8'(i));
      chk("fill_hi", got[2 * i + 1], 8'hA1);
    end

    // Stall in HI
    out_ready = 0; in_valid = 1; in_data = 16'h1234;
    tick();
    in_valid = 0;
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    wc0 = word_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_byte", out_byte, 8'h12);
      chk("stall_hi", out_hi, 1);
      chk("stall_count", word_count, wc0);
    end
    out_ready = 1;
    tick();
    chk("stall_accept_count", word_count, wc0 + 1);

    // Clear in LO with two queued
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 16'h5500 + 16'(i);
      tick();
    end
    in_valid = 0;
    chk("clr_pre_lo", out_hi, 0);
    chk("clr_pre_valid", out_valid, 1);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_valid", out_valid, 0);
    chk("clr_count", word_count, 0);
    chk("clr_in_ready", in_ready, 1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_quiet", out_valid, 0);
    end

    // Stream 300 words, saturation
    n = 0;
    for (int cyc = 0; cyc < 2000 && n < 300; cyc++) begin
      in_valid = 1; in_data = 16'(n * 7);
      if (in_ready) n++;
      tick();
    end
    in_valid = 0;
    chk("stream_accepted", n, 300);
    for (int cyc = 0; cyc < 40 && out_valid; cyc++) tick();
    chk("sat_count", word_count, 255);

    // Reset mid-stream
    in_valid = 1; in_data = 16'hBEEF;
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_byte", out_byte, 0);
    chk("arst_hi", out_hi, 0);
    chk("arst_flags", {flag_nan, flag_zero}, 0);
    chk("arst_count", word_count, 0);
    chk("arst_in_ready", in_ready, 1);
    in_valid = 0;
    tick();
    rst_n = 1;
    tick(); tick();
    chk("post_rst_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/dlfloat_result_serializer.md
DLFLOAT_RESULT_SERIALIZER -- requirements
Module: dlfloat_result_serializer

Interface
REQ-001: Parameter DEPTH, default 4, result FIFO depth in 16-bit words; SHALL be a power of two in the range 2..16.
REQ-002: clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: clear  input  1  synchronous flush, active-high.
REQ-005: in_valid  input  1  a DLFloat result is presented on in_data.
REQ-006: in_data  input  16  DLFloat result {sign[15], exp[14:9], mant[8:0]}.
REQ-007: in_ready  output  1  the block can accept a word this cycle.
REQ-008: out_byte  output  8  serialized result byte.
REQ-009: out_valid  output  1  out_byte and the out_* flags are valid.
REQ-010: out_ready  input  1  the consumer accepts out_byte this cycle.
REQ-011: out_hi  output  1  0 = low byte [7:0], 1 = high byte [15:8] of the current word.
REQ-012: flag_nan  output  1  the current word equals 16'hFFFF.
REQ-013: flag_zero  output  1  the current word equals 16'h0000.
REQ-014: word_count  output  8  number of fully transmitted words.

Function
REQ-015: in_ready SHALL equal NOT fifo_full and SHALL be decoded from registered state only; there is no combinational path from out_ready to in_ready.
REQ-016: A push SHALL occur on an edge where in_valid=1 and in_ready=1; the word is written at the write pointer, and the pointer wraps modulo DEPTH.
REQ-017: When the FIFO is full, in_ready SHALL be 0 and in_data SHALL be ignored, even if a pop occurs in the same cycle.
REQ-018: Full and empty detection SHALL use pointers one bit wider than log2(DEPTH); the occupancy count SHALL stay in the range 0..DEPTH.
REQ-019: The FSM SHALL have three states: IDLE (out_valid=0), LO (out_valid=1, out_hi=0) and HI (out_valid=1, out_hi=1).
REQ-020: In IDLE with the FIFO non-empty, the FSM SHALL pop the head word into the hold register and go to LO on the next edge; with the FIFO empty it SHALL stay in IDLE.
REQ-021: In LO, out_ready=1 SHALL cause a transition to HI, and out_ready=0 SHALL hold LO.
REQ-022: In HI, out_ready=1 SHALL increment word_count; the FSM SHALL then pop the next word and go to LO if the FIFO is non-empty, otherwise go to IDLE. out_ready=0 SHALL hold HI.
REQ-023: out_byte SHALL be hold[7:0] in LO and hold[15:8] in HI, and SHALL be 0 in IDLE.
REQ-024: While out_valid=1 and out_ready=0, out_byte, out_hi and the flags SHALL remain stable.
REQ-025: flag_nan and flag_zero SHALL be registered along with the hold register, SHALL be constant across the LO and HI bytes of a word, and SHALL be 0 in IDLE.
REQ-026: Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE SHALL appear as the low byte with out_valid=1 after edge N+1.
REQ-027: Throughput: with out_ready held at 1, the block SHALL deliver one word per 2 cycles with no IDLE gap between queued words.
REQ-028: A push and a pop in the same cycle SHALL both take effect, and occupancy SHALL be unchanged.
REQ-029: word_count SHALL saturate at 255 and never wrap.
REQ-030: clear=1 SHALL, on the next edge, empty the FIFO, reset both pointers, force the FSM to IDLE, zero word_count, hold and flags, and discard any push offered in that cycle; clear SHALL take priority over all other events.
REQ-031: A word that is mid-transmission when clear is asserted SHALL be dropped; no high byte SHALL follow it.
REQ-032: The FIFO payload SHALL be opaque; no DLFloat arithmetic or normalisation SHALL be performed on it.

Reset
REQ-033: While rst_n=0, the FSM SHALL be IDLE, the pointers 0, and out_byte, out_valid, out_hi, flag_nan, flag_zero and word_count all 0; in_ready SHALL be 1.
REQ-034: Deassertion of rst_n SHALL take effect on the next rising edge with no extra synchronisation cycle inside the block.
REQ-035: Reset asserted mid-word SHALL drop all buffered and in-flight data.

Verification
REQ-036: Push 16'h3E00 with out_ready=1 -> out_byte 8'h00 (out_hi=0) then 8'h3E (out_hi=1); word_count becomes 1; flags 0.
REQ-037: Push 16'hFFFF and then 16'h0000 back-to-back with out_ready=1 -> bytes FF, FF, 00, 00 on consecutive cycles; flag_nan=1 for the first word, flag_zero=1 for the second.
REQ-038: Hold out_ready=0 and push DEPTH+1 words -> in_ready falls after the push that fills the FIFO (the FSM has already pulled the first word into hold); the extra word is rejected; then release out_ready -> exactly the accepted words emerge in order, with the pointers wrapping.
REQ-039: Stall out_ready=0 in HI for 5 cycles -> out_byte and flags stay stable; word_count increments only on the accepting edge.
REQ-040: Assert clear in LO with 2 words queued -> next cycle out_valid=0, word_count=0, in_ready=1, and no further bytes appear.
REQ-041: Stream 300 words -> word_count saturates at 255; assert rst_n=0 mid-stream -> all outputs 0 and in_ready=1.
